dc_motor_reversal_ctrl: RTL and testbench
=========================================

Name: dc_motor_reversal_ctrl

Overview:
Sequences the SN754410 half-bridge pair for one DC motor. It owns the A1/A2 direction inputs and the EN pin. Start, stop and direction reversal always pass through a timed brake then dead-time interval, never a direct polarity flip. After every start, the drive ramps (soft-start) to the requested PWM duty. It sits between the lab's Nios PIO/switch registers and the motor driver pins, replacing the free-running direction decoder.

Parameters:
BRAKE_CYCLES, 12000, clocks spent in brake state (1 ms at 12 MHz); minimum 1
DEAD_CYCLES, 1200, clocks with bridge fully off after braking, before new polarity; minimum 1
RAMP_DIV, 4700, clocks per +1 step of ramp level; minimum 1
CNT_W, 16, width of the shared interval counter; must hold max(BRAKE_CYCLES, DEAD_CYCLES, RAMP_DIV)

Ports:
clk  in  1  system clock, single clock domain
reset_n  in  1  asynchronous active-low reset
run_req  in  1  1 = motor should run, 0 = stop
dir_req  in  1  0 = clockwise, 1 = counter-clockwise
duty  in  8  target PWM duty, EN high for duty/256 of each PWM period
motor_driver_inputs  out  2  bit0 -> A1, bit1 -> A2
motor_enable  out  1  SN754410 EN pin (PWM or brake hold)
busy  out  1  high in RAMP, BRAKE and DEAD
state_o  out  3  current state encoding, for debug/PIO readback

Behaviour:
- Clock and reset: clk is the single clock. reset_n is asynchronous and active-low. Reset forces:
  - state = IDLE, cur_dir = 0, level = 0, interval counter = 0, PWM counter = 0
  - motor_driver_inputs = 2'b00, motor_enable = 0, busy = 0, state_o = IDLE
- Reset assertion mid-operation, including in BRAKE or DEAD, drops to IDLE immediately with the bridge off. There is no brake on reset.
- Drive encoding:
  - CW = 2'b10 (A1=0, A2=1)
  - CCW = 2'b01 (A1=1, A2=0)
  - BRAKE/OFF = 2'b00
  - 2'b11 is never driven.
- Output timing: all outputs are Moore functions of registered state, cur_dir, level and the PWM counter. There is no combinational path from input to output. An input sampled at edge N changes outputs right after edge N.
- PWM: an 8-bit free-running counter pwm_cnt increments every clock and wraps 255 -> 0. pwm_on = (pwm_cnt < L), where L is the active level. L = 0 gives EN constantly low. L = 255 gives 255 high clocks out of 256.
- State IDLE (encoding 0):
  - drv = 00, EN = 0
  - run_req = 1 -> cur_dir <= dir_req, level <= 0, counter <= 0, go to RAMP
- State RAMP (encoding 1):
  - drv = cur_dir encoding, EN = pwm_on with L = level
  - Counter counts to RAMP_DIV-1, then level <= level+1 and the counter clears.
  - When level >= duty, go to RUN. This is checked every clock, and duty may change live.
  - If duty = 0 on entry, go to RUN on the next clock.
- State RUN (encoding 2):
  - drv = cur_dir encoding, EN = pwm_on with L = duty (live)
  - Raising duty does not re-ramp.
- Exit from RAMP or RUN, in priority order:
  - run_req = 0 -> BRAKE
  - dir_req != cur_dir -> BRAKE
  - The counter clears on entry to BRAKE.
- State BRAKE (encoding 3):
  - drv = 00, EN = 1 (both low-side on, dynamic brake)
  - After exactly BRAKE_CYCLES clocks in this state -> DEAD, counter cleared
- State DEAD (encoding 4):
  - drv = 00, EN = 0
  - After exactly DEAD_CYCLES clocks in this state:
    - if run_req = 1: cur_dir <= dir_req, level <= 0, go to RAMP
    - otherwise go to IDLE
- Inputs during BRAKE and DEAD: run_req and dir_req are ignored except at the DEAD exit decision. A dir_req toggling back and forth during braking still completes the full brake plus dead sequence.
- Simultaneous run_req and dir_req changes: run_req = 0 takes priority. Both lead to BRAKE, so the result is the same.
- busy = 1 in states 1, 3 and 4.
- Unused encodings 5–7 recover to IDLE on the next clock.
- Counter arithmetic: unsigned CNT_W bits, never wraps in legal use. level is 8 bits and saturates at 255.

Decomposition:
- Package dc_motor_pkg holds:
  - state encodings: IDLE, RAMP, RUN, BRAKE, DEAD
  - drive constants: DRV_CW = 2'b10, DRV_CCW = 2'b01, DRV_OFF = 2'b00
- One sub-module, motor_pwm_gen:
  - contains the 8-bit free-running counter and the compare
  - inputs: clk, reset_n, level[7:0]
  - output: pwm_on
- The FSM, interval counter and ramp level stay in dc_motor_reversal_ctrl.

Test Plan:
All scenarios use BRAKE_CYCLES = 4, DEAD_CYCLES = 2, RAMP_DIV = 1.
- Reset: hold reset_n = 0 while running -> outputs immediately 00/0, busy = 0, state_o = 0. Release with run_req = 0 -> stays in IDLE.
- Start CW with duty = 8: run_req = 1, dir_req = 0 -> drv = 10 the next cycle, level steps 0 -> 8 one per clock, RUN is reached, then EN is high for 8 of every 256 clocks.
- Reversal CW to CCW in RUN: toggle dir_req -> exactly 4 clocks of drv = 00 with EN = 1, then 2 clocks of drv = 00 with EN = 0, then drv = 01 and the ramp restarts from 0. drv never equals 11 at any point.
- Stop during RAMP: drop run_req at level = 3 -> BRAKE for 4 clocks, DEAD for 2 clocks, then IDLE with busy = 0.
- dir_req glitch during BRAKE: dir toggles 0 -> 1 -> 0 inside BRAKE with run_req = 1 -> full 4 + 2 sequence completes, RAMP resumes with drv = 10.
- Edge duties: duty = 0 gives RUN with EN always 0. duty = 255 gives EN low exactly 1 clock per 256 clocks.

Source files
------------

// File: rtl/dc_motor_pkg.sv
// Shared encodings for the DC motor reversal controller: FSM states and
// SN754410 A2/A1 drive patterns.
package dc_motor_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RAMP  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_BRAKE = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  localparam logic [1:0] DRV_CW  = 2'b10;
  localparam logic [1:0] DRV_CCW = 2'b01;
  localparam logic [1:0] DRV_OFF = 2'b00;

  function automatic logic [1:0] drv_for_dir(input logic dir);
    return dir ? DRV_CCW : DRV_CW;
  endfunction

endpackage

// File: rtl/dc_motor_reversal_ctrl_pwm.sv
// Free-running 8-bit PWM counter; pwm_on is high while the count is below level.
module motor_pwm_gen (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] level,
  output logic       pwm_on
);

  logic [7:0] pwm_cnt_q;
  logic [7:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < level);

endmodule

// File: rtl/dc_motor_reversal_ctrl.sv
// Direction/enable sequencer for one SN754410-driven DC motor: every start,
// stop or reversal goes through brake and dead time, starts soft-ramp the duty.
module dc_motor_reversal_ctrl
  import dc_motor_pkg::*;
#(
  parameter int BRAKE_CYCLES = 12000,
  parameter int DEAD_CYCLES  = 1200,
  parameter int RAMP_DIV     = 4700,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_req,
  input  logic       dir_req,
  input  logic [7:0] duty,
  output logic [1:0] motor_driver_inputs,
  output logic       motor_enable,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             cur_dir_q, cur_dir_d;
  logic [7:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_on;
  logic             stop_req;

  // In RUN, level_q tracks duty so EN stays a function of registered state only.
  motor_pwm_gen u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (level_q),
    .pwm_on  (pwm_on)
  );

  assign stop_req = !run_req || (dir_req != cur_dir_q);

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run_req) begin
          cur_dir_d = dir_req;
          level_d   = 8'd0;
          cnt_d     = '0;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (stop_req) begin
          cnt_d   = '0;
          state_d = ST_BRAKE;
        end else if (level_q >= duty) begin
          level_d = duty;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == RAMP_LAST) begin
          cnt_d = '0;
          if (level_q != 8'hFF) begin
            level_d = level_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          cnt_d   = '0;
          state_d = ST_BRAKE;
        end else begin
          level_d = duty;
        end
      end
      ST_BRAKE: begin
        if (cnt_q == BRAKE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DEAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d = '0;
          if (run_req) begin
            cur_dir_d = dir_req;
            level_d   = 8'd0;
            state_d   = ST_RAMP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 8'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cur_dir_q <= 1'b0;
      level_q   <= 8'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    motor_driver_inputs = DRV_OFF;
    motor_enable        = 1'b0;
    busy                = 1'b0;
    case (state_q)
      ST_RAMP: begin
        motor_driver_inputs = drv_for_dir(cur_dir_q);
        motor_enable        = pwm_on;
        busy                = 1'b1;
      end
      ST_RUN: begin
        motor_driver_inputs = drv_for_dir(cur_dir_q);
        motor_enable        = pwm_on;
      end
      ST_BRAKE: begin
        motor_enable = 1'b1;
        busy         = 1'b1;
      end
      ST_DEAD: begin
        busy = 1'b1;
      end
      default: begin
        motor_driver_inputs = DRV_OFF;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_dc_motor_reversal_ctrl.sv
// Scoreboard bench: a phase/time-left reference model queues expected outputs
// per clock; a monitor pops and compares them on the falling edge.
module tb_dc_motor_reversal_ctrl;

  localparam int BRAKE_N = 4;
  localparam int DEAD_N  = 2;
  localparam int RDIV    = 1;

  localparam int P_IDLE  = 0;
  localparam int P_RAMP  = 1;
  localparam int P_RUN   = 2;
  localparam int P_BRAKE = 3;
  localparam int P_DEAD  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_req = 1'b0;
  logic       dir_req = 1'b0;
  logic [7:0] duty = 8'd0;
  logic [1:0] motor_driver_inputs;
  logic       motor_enable;
  logic       busy;
  logic [2:0] state_o;

  dc_motor_reversal_ctrl #(
    .BRAKE_CYCLES (BRAKE_N),
    .DEAD_CYCLES  (DEAD_N),
    .RAMP_DIV     (RDIV),
    .CNT_W        (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .run_req             (run_req),
    .dir_req             (dir_req),
    .duty                (duty),
    .motor_driver_inputs (motor_driver_inputs),
    .motor_enable        (motor_enable),
    .busy                (busy),
    .state_o             (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] drv;
    logic       en;
    logic       busy;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase plus "clocks left" and a wall-clock PWM position.
  initial begin : model
    int   phase, dir, lvl, tick, left, run_lvl, pwm;
    exp_t e;
    phase = P_IDLE; dir = 0; lvl = 0; tick = 0; left = 0; run_lvl = 0; pwm = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        phase = P_IDLE; dir = 0; lvl = 0; tick = 0; left = 0; run_lvl = 0; pwm = 0;
      end else begin
        case (phase)
          P_IDLE: if (run_req) begin
            phase = P_RAMP; dir = int'(dir_req); lvl = 0; tick = 0;
          end
          P_RAMP: begin
            if (!run_req || int'(dir_req) != dir) begin
              phase = P_BRAKE; left = BRAKE_N;
            end else if (lvl >= int'(duty)) begin
              phase = P_RUN; run_lvl = int'(duty);
            end else begin
              tick++;
              if (tick == RDIV) begin
                tick = 0;
                lvl = (lvl < 255) ? lvl + 1 : 255;
              end
            end
          end
          P_RUN: begin
            if (!run_req || int'(dir_req) != dir) begin
              phase = P_BRAKE; left = BRAKE_N;
            end else begin
              run_lvl = int'(duty);
            end
          end
          P_BRAKE: begin
            left--;
            if (left == 0) begin
              phase = P_DEAD; left = DEAD_N;
            end
          end
          default: begin
            left--;
            if (left == 0) begin
              if (run_req) begin
                phase = P_RAMP; dir = int'(dir_req); lvl = 0; tick = 0;
              end else begin
                phase = P_IDLE;
              end
            end
          end
        endcase
        pwm = (pwm + 1) % 256;
        e.st   = 3'(phase);
        e.busy = (phase == P_RAMP || phase == P_BRAKE || phase == P_DEAD);
        e.drv  = (phase == P_RAMP || phase == P_RUN) ? (dir != 0 ? 2'b01 : 2'b10) : 2'b00;
        e.en   = (phase == P_BRAKE) ||
                 (phase == P_RAMP && pwm < lvl) ||
                 (phase == P_RUN && pwm < run_lvl);
        exp_q.push_back(e);
      end
    end
  end

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s t=%0t actual drv=%b en=%b busy=%b st=%0d required drv=%b en=%b busy=%b st=%0d",
                 name, $time, act.drv, act.en, act.busy, act.st,
                 req.drv, req.en, req.busy, req.st);
    end
  endtask

  initial begin : monitor
    exp_t act, req;
    forever begin
      @(negedge clk);
      act = '{drv: motor_driver_inputs, en: motor_enable, busy: busy, st: state_o};
      if (!reset_n) begin
        check("reset_hold", act, '0);
      end else if (exp_q.size() > 0) begin
        req = exp_q.pop_front();
        check("outputs", act, req);
      end
    end
  end

  task automatic seg(input logic r, input logic d, input logic [7:0] du, input int n);
    run_req = r;
    dir_req = d;
    duty    = du;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; reset is asserted and released clear of both edges.
  task automatic pulse_reset(input logic r_hold);
    exp_t act;
    #2;
    reset_n = 1'b0;
    run_req = r_hold;
    #1;
    act = '{drv: motor_driver_inputs, en: motor_enable, busy: busy, st: state_o};
    check("reset_async", act, '0);
    repeat (2) @(negedge clk);
    run_req = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    logic r, d;
    logic [7:0] du;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    seg(0, 0, 8'd0, 5);
    seg(1, 0, 8'd8, 600);
    seg(1, 1, 8'd8, 40);
    pulse_reset(1'b1);
    seg(0, 0, 8'd10, 5);
    seg(1, 0, 8'd10, 4);
    seg(0, 0, 8'd10, 12);
    seg(1, 0, 8'd20, 40);
    seg(1, 1, 8'd20, 1);
    seg(1, 0, 8'd20, 1);
    seg(1, 1, 8'd20, 1);
    seg(1, 0, 8'd20, 30);
    seg(1, 0, 8'd0, 300);
    seg(1, 0, 8'd255, 600);
    seg(0, 0, 8'd255, 10);
    seg(1, 1, 8'd255, 800);
    r = 1'b1; d = 1'b0; du = 8'd40;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r = ~r;
      if ($urandom_range(0, 59) == 0) d = ~d;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: du = 8'd0;
          1: du = 8'd255;
          default: du = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 999) == 0) pulse_reset(r);
      seg(r, d, du, 1);
    end
    seg(0, 0, 8'd0, 12);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
